// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: IF/ID, decoder, write-back and EX-side signals of id_ex_stage.
// Defining ID_PERF_CNT_EN adds the performance counter outputs.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
);
    logic              valid_i;
    logic [31:0]       inst_i;
    logic [XLEN-1:0]   pc_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [XLEN-1:0]   imm_i;
    logic              use_rs1_i;
    logic              use_rs2_i;
    logic              is_load_i;
    logic              reg_we_i;
    logic              hold_i;
    logic              flush_i;
    logic              wb_we_i;
    logic [4:0]        wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [4:0]        ex_rs1_o;
    logic [4:0]        ex_rs2_o;
    logic [4:0]        ex_rd_o;
    logic              ex_reg_we_o;
    logic              ex_is_load_o;
    logic              ex_illegal_o;
`ifdef ID_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt_o;
    logic [31:0]       perf_flush_cnt_o;
`endif

    modport slave (
        input  valid_i, inst_i, pc_i, ctrl_i, imm_i,
        input  use_rs1_i, use_rs2_i, is_load_i, reg_we_i,
        input  hold_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
        output stall_o, ex_valid_o, ex_pc_o, ex_ctrl_o, ex_imm_o,
        output ex_rs1_data_o, ex_rs2_data_o,
        output ex_rs1_o, ex_rs2_o, ex_rd_o,
        output ex_reg_we_o, ex_is_load_o, ex_illegal_o
`ifdef ID_PERF_CNT_EN
        , output perf_stall_cnt_o, perf_flush_cnt_o
`endif
    );

    modport master (
        output valid_i, inst_i, pc_i, ctrl_i, imm_i,
        output use_rs1_i, use_rs2_i, is_load_i, reg_we_i,
        output hold_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
        input  stall_o, ex_valid_o, ex_pc_o, ex_ctrl_o, ex_imm_o,
        input  ex_rs1_data_o, ex_rs2_data_o,
        input  ex_rs1_o, ex_rs2_o, ex_rd_o,
        input  ex_reg_we_o, ex_is_load_o, ex_illegal_o
`ifdef ID_PERF_CNT_EN
        , input perf_stall_cnt_o, perf_flush_cnt_o
`endif
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: register file with write-first bypass, load-use bubble and ID/EX
// register with flush/hold. Define ID_PERF_CNT_EN for stall/flush counters.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CTRL_W   = 16
) (
    input logic          clk_i,
    input logic          reset_n,
    id_ex_stage_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    function automatic logic in_range(input logic [4:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    logic [4:0]      rs1, rs2, rd;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            unused_inst;

    assign rs1         = bus.inst_i[19:15];
    assign rs2         = bus.inst_i[24:20];
    assign rd          = bus.inst_i[11:7];
    assign wb_we       = bus.wb_we_i;
    assign wb_rd       = bus.wb_rd_i;
    assign wb_data     = bus.wb_data_i;
    assign unused_inst = ^{bus.inst_i[31:25], bus.inst_i[14:12], bus.inst_i[6:0]};

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_en;

    assign wr_en = wb_we && (wb_rd != 5'd0) && in_range(wb_rd);

    always_ff @(posedge clk_i or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_data, rs2_data;

    // write-first: a same-cycle write-back wins over the stored value
    always_comb begin
        rs1_data = '0;
        if (rs1 != 5'd0 && in_range(rs1))
            rs1_data = (wb_we && wb_rd == rs1) ? wb_data : regs[rs1[AW-1:0]];
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 != 5'd0 && in_range(rs2))
            rs2_data = (wb_we && wb_rd == rs2) ? wb_data : regs[rs2[AW-1:0]];
    end

    logic              ex_valid, ex_reg_we, ex_is_load, ex_illegal;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              illegal, hazard, stall;

    assign illegal = bus.valid_i & (
        (bus.use_rs1_i & ~in_range(rs1)) |
        (bus.use_rs2_i & ~in_range(rs2)) |
        (bus.reg_we_i  & ~in_range(rd)));

    assign hazard = bus.valid_i & ex_valid & ex_is_load & (ex_rd != 5'd0) &
        ((bus.use_rs1_i & (rs1 == ex_rd)) | (bus.use_rs2_i & (rs2 == ex_rd)));

    assign stall = hazard & ~bus.hold_i & ~bus.flush_i;

    always_ff @(posedge clk_i or posedge reset_n) begin
        if (reset_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_ctrl     <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_reg_we   <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (bus.flush_i || (!bus.hold_i && stall)) begin
            ex_valid   <= 1'b0;
            ex_reg_we  <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (!bus.hold_i) begin
            ex_valid    <= bus.valid_i;
            ex_pc       <= bus.pc_i;
            ex_ctrl     <= bus.ctrl_i;
            ex_imm      <= bus.imm_i;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_reg_we   <= bus.reg_we_i & bus.valid_i & (rd != 5'd0);
            ex_is_load  <= bus.is_load_i;
            ex_illegal  <= illegal;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.ex_valid_o    = ex_valid;
    assign bus.ex_pc_o       = ex_pc;
    assign bus.ex_ctrl_o     = ex_ctrl;
    assign bus.ex_imm_o      = ex_imm;
    assign bus.ex_rs1_data_o = ex_rs1_data;
    assign bus.ex_rs2_data_o = ex_rs2_data;
    assign bus.ex_rs1_o      = ex_rs1;
    assign bus.ex_rs2_o      = ex_rs2;
    assign bus.ex_rd_o       = ex_rd;
    assign bus.ex_reg_we_o   = ex_reg_we;
    assign bus.ex_is_load_o  = ex_is_load;
    assign bus.ex_illegal_o  = ex_illegal;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    // both counters saturate instead of wrapping
    always_ff @(posedge clk_i or posedge reset_n) begin
        if (reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.flush_i && ex_valid && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt_o = stall_cnt;
    assign bus.perf_flush_cnt_o = flush_cnt;
`endif
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Parametrised decode stage for the pipelined core. It contains the register file with same-cycle write-back bypass, load-use hazard detection with bubble insertion, and the ID/EX pipeline register with flush and hold control. It takes the fetched instruction and PC from IF/ID, and the control word and immediate from the external decoder. It hands a registered, valid-qualified bundle to EX.

Parameters:
XLEN, 32, datapath width of registers, operands, immediate and PC.
NUM_REGS, 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E).
CTRL_W, 16, width of the opaque decoder control word carried to EX.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-high reset (asserted = 1).
valid_i  in  1  IF/ID holds a real instruction.
inst_i  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
pc_i  in  XLEN  PC of inst_i.
ctrl_i  in  CTRL_W  decoder control word.
imm_i  in  XLEN  decoded immediate.
use_rs1_i  in  1  instruction reads rs1.
use_rs2_i  in  1  instruction reads rs2.
is_load_i  in  1  instruction is a load.
reg_we_i  in  1  instruction writes rd.
hold_i  in  1  downstream stall; freeze ID/EX.
flush_i  in  1  branch/jump redirect; kill ID/EX contents.
wb_we_i  in  1  write-back enable.
wb_rd_i  in  5  write-back destination.
wb_data_i  in  XLEN  write-back data.
stall_o  out  1  load-use stall request to IF and IF/ID (hold them).
ex_valid_o  out  1  ID/EX holds a real instruction.
ex_pc_o  out  XLEN  registered PC.
ex_ctrl_o  out  CTRL_W  registered control word.
ex_imm_o  out  XLEN  registered immediate.
ex_rs1_data_o, ex_rs2_data_o  out  XLEN  registered operands.
ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered register indices, for EX forwarding.
ex_reg_we_o  out  1  registered write enable, forced to 0 when rd==0.
ex_is_load_o  out  1  registered load flag.
ex_illegal_o  out  1  registered illegal-register flag.

Behaviour:
- Reset: all ID/EX outputs are 0 and all registers are 0. Reset takes effect asynchronously on assertion; the first capture happens on the first clock edge after deassertion.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write on clock edge when wb_we_i=1, wb_rd_i!=0 and wb_rd_i<NUM_REGS; indices ≥NUM_REGS are dropped.
  - Read bypass: when wb_we_i=1, wb_rd_i==rs, rs!=0 and rs<NUM_REGS, the read returns wb_data_i in the same cycle (write-first).
  - Source reads with index ≥NUM_REGS return 0.
- Illegal register: illegal = valid_i & ((use_rs1_i & rs1≥NUM_REGS) | (use_rs2_i & rs2≥NUM_REGS) | (reg_we_i & rd≥NUM_REGS)). It is captured into ex_illegal_o. Always 0 when NUM_REGS=32.
- Load-use hazard: stall_o = valid_i & ex_valid_o & ex_is_load_o & (ex_rd_o!=0) & ((use_rs1_i & rs1==ex_rd_o) | (use_rs2_i & rs2==ex_rd_o)). The output is combinational. It is forced to 0 while hold_i=1 or flush_i=1.
- ID/EX update priority per edge:
  1. flush_i: ex_valid_o←0, ex_reg_we_o←0, ex_is_load_o←0; data fields don't-care. Flush overrides hold_i.
  2. hold_i: all ID/EX fields keep their value.
  3. stall_o: bubble inserted; ex_valid_o←0, ex_reg_we_o←0, ex_is_load_o←0. The IF/ID instruction is re-presented by upstream next cycle.
  4. Otherwise capture all inputs; ex_valid_o←valid_i; ex_reg_we_o←reg_we_i & valid_i & rd!=0.
- Latency: 1 cycle from IF/ID to EX. A load-use pair incurs exactly 1 bubble.
- Write-back during hold: the register file still writes. Held operands are not refreshed; EX forwarding covers that case.

Optional Feature:
Macro ID_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt_o (32) and perf_flush_cnt_o (32).
  - perf_stall_cnt_o increments on each cycle stall_o=1.
  - perf_flush_cnt_o increments on each edge where flush_i=1 and ex_valid_o=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent and core behaviour is identical.

Test Plan:
- Reset then idle: reset_n=1 for 2 cycles, then release with valid_i=0 → all ex_* outputs are 0, stall_o=0, and reads of x1..x31 return 0.
- Write-bypass: wb_we_i=1, wb_rd_i=5, wb_data_i=0xDEADBEEF, with inst_i=add x3,x5,x0 and valid_i=1 in the same cycle → ex_rs1_data_o=0xDEADBEEF next cycle. A write with wb_rd_i=0 leaves x0 reading 0.
- Load-use: lw x7 captured, then add x8,x7,x1 presented → stall_o=1 for one cycle and ex_valid_o=0 (bubble). Next cycle the add is captured with ex_valid_o=1.
- No false stall: lw x0 followed by use of x0 → stall_o=0. lw x7 followed by lui x7 (use_rs1_i=use_rs2_i=0) → stall_o=0.
- Flush vs hold: hold_i=1 and flush_i=1 in the same cycle → ex_valid_o=0 next cycle. hold_i=1 alone for 3 cycles → all ex_* outputs are unchanged.
- NUM_REGS=16: add x3,x20,x1 → ex_illegal_o=1 and ex_rs1_data_o=0. A write-back to x20 is ignored.
